// File: rtl/mem_access_unit.sv
// Load/store front end: big-endian byte/half/word accesses over a word-wide memory, with read-modify-write for sub-word stores.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses raise misalign instead of being force-aligned.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  busy
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_cnt;
  logic [1:0]            w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic                  r_write;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_trap;
  logic                  w_resp_load;
  logic [ADDR_WIDTH-1:0] w_addr_in;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_ext;
  logic [31:0]           w_merged;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_capture = (r_state == S_RD_WAIT) && (r_cnt == 2'd0);

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misaligned;

  assign w_misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
  assign w_trap       = w_misaligned;
  assign w_addr_in    = req_addr;
  assign w_resp_load  = !r_write && !r_misalign;
  assign misalign     = (r_state == S_RESP) && r_misalign;
`else
  assign w_trap      = 1'b0;
  assign w_resp_load = !r_write;

  // Without the trap, misaligned low address bits are simply dropped.
  always_comb begin
    w_addr_in = req_addr;
    if (req_size[1]) begin
      w_addr_in[1:0] = 2'b00;
    end else if (req_size == SZ_HALF) begin
      w_addr_in[0] = 1'b0;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_addr   <= '0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_write  <= 1'b0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr   <= w_addr_in;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_write  <= req_write;
        r_wdata  <= req_wdata;
`ifdef MISALIGN_TRAP_EN
        r_misalign <= w_trap;
`endif
      end
      if (w_capture) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_trap) begin
            w_state_nxt = S_RESP;
          end else if (req_write && req_size[1]) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        w_state_nxt = S_RD_WAIT;
        w_cnt_nxt   = CNT_INIT;
      end
      S_RD_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = r_write ? S_WR : S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      S_WR:    w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Big-endian lane select: byte offset 0 is the most significant byte.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = r_rdata[31:24];
      2'd1:    w_byte = r_rdata[23:16];
      2'd2:    w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_addr[1] ? r_rdata[15:0] : r_rdata[31:16];
    case (r_size)
      SZ_BYTE: w_load_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_ext = r_rdata;
    endcase
  end

  always_comb begin
    w_merged = r_rdata;
    case (r_size)
      SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0:    w_merged[31:24] = r_wdata[7:0];
          2'd1:    w_merged[23:16] = r_wdata[7:0];
          2'd2:    w_merged[15:8]  = r_wdata[7:0];
          default: w_merged[7:0]   = r_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (r_addr[1]) begin
          w_merged[15:0] = r_wdata[15:0];
        end else begin
          w_merged[31:16] = r_wdata[15:0];
        end
      end
      default: w_merged = r_wdata;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    busy       = (r_state != S_IDLE);
    mem_read   = (r_state == S_RD);
    mem_write  = (r_state == S_WR);
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    if (r_state inside {S_RD, S_RD_WAIT, S_WR}) begin
      mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    end
    if (r_state == S_WR) begin
      mem_wdata = w_merged;
    end
    if (r_state == S_RESP) begin
      resp_valid = 1'b1;
      if (w_resp_load) begin
        resp_data = w_load_ext;
      end
    end
  end

endmodule
